// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one nibble parity evaluator among NUM_REQ requesters,
// with a saturating error counter and a sticky error LED.
module parity_check_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  ERR_CNT_W  = 8,
  parameter int  PARITY_ODD = 0,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_par,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDX_W-1:0]       res_id,
  output logic                   res_parity,
  output logic                   res_err,
  input  logic                   clr_err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic                   led
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EVAL, S_RESP} state_e;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  function automatic logic calc_parity(input logic [3:0] nib);
    calc_parity = (^nib) ^ 1'(PARITY_ODD);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [3:0]             nib_q, nib_d;
  logic                   par_q, par_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic [IDX_W-1:0]       res_id_q, res_id_d;
  logic                   res_parity_q, res_parity_d;
  logic                   res_err_q, res_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   led_q, led_d;

  logic [IDX_W:0]         sum_s, cand_s;
  logic                   hit_s, found_s;
  logic [IDX_W-1:0]       pick_s;
  logic [ERR_CNT_W-1:0]   cnt_base_s;
  logic                   led_base_s;
  logic                   hs_err_s;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    sum_s   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s   = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      cand_s  = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? sum_s - (IDX_W+1)'(NUM_REQ) : sum_s;
      hit_s   = req_valid[cand_s[IDX_W-1:0]] & ~found_s;
      pick_s  = hit_s ? cand_s[IDX_W-1:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and datapath for the GRANT/EVAL/RESP sequence and error tracking.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    nib_d        = nib_q;
    par_d        = par_q;
    req_ready_d  = {NUM_REQ{1'b0}};
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_parity_d = res_parity_q;
    res_err_d    = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d     = S_GRANT;
          grant_d     = pick_s;
          req_ready_d = onehot(pick_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // A withdrawn request is dropped without advancing the pointer.
        if (req_valid[grant_q]) begin
          nib_d    = req_data[{grant_q, 2'b00} +: 4];
          par_d    = req_par[grant_q];
          rr_ptr_d = next_idx(grant_q);
          state_d  = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        res_parity_d = calc_parity(nib_q);
        res_err_d    = calc_parity(nib_q) ^ par_q;
        res_id_d     = grant_q;
        res_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Clear applies before the increment so a coincident error still counts.
    hs_err_s = res_valid_q & res_ready & res_err_q;
    if (clr_err) begin
      cnt_base_s = {ERR_CNT_W{1'b0}};
      led_base_s = 1'b0;
    end else begin
      cnt_base_s = err_cnt_q;
      led_base_s = led_q;
    end
    if (hs_err_s) begin
      err_cnt_d = (cnt_base_s == ERR_MAX) ? ERR_MAX : cnt_base_s + ERR_CNT_W'(1);
      led_d     = 1'b1;
    end else begin
      err_cnt_d = cnt_base_s;
      led_d     = led_base_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= {IDX_W{1'b0}};
      grant_q      <= {IDX_W{1'b0}};
      nib_q        <= 4'h0;
      par_q        <= 1'b0;
      req_ready_q  <= {NUM_REQ{1'b0}};
      res_valid_q  <= 1'b0;
      res_id_q     <= {IDX_W{1'b0}};
      res_parity_q <= 1'b0;
      res_err_q    <= 1'b0;
      err_cnt_q    <= {ERR_CNT_W{1'b0}};
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      nib_q        <= nib_d;
      par_q        <= par_d;
      req_ready_q  <= req_ready_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_parity_q <= res_parity_d;
      res_err_q    <= res_err_d;
      err_cnt_q    <= err_cnt_d;
      led_q        <= led_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_parity = res_parity_q;
  assign res_err    = res_err_q;
  assign err_cnt    = err_cnt_q;
  assign led        = led_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter: scoreboard of expected results,
// reference round-robin pointer and saturating counter model.
module tb_parity_check_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_par;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_id;
  logic                 res_parity;
  logic                 res_err;
  logic                 clr_err;
  logic [ERR_W-1:0]     err_cnt;
  logic                 led;

  typedef struct packed {
    logic [1:0] id;
    logic       parity;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_rr  = 0;
  int   model_cnt = 0;
  logic model_led = 1'b0;
  logic last_err  = 1'b0;

  parity_check_arbiter #(.NUM_REQ(NUM_REQ), .ERR_CNT_W(ERR_W), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_par(req_par), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_parity(res_parity), .res_err(res_err),
    .clr_err(clr_err), .err_cnt(err_cnt), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [3:0] nib, input logic par);
    exp_t e;
    e.id     = 2'(idx);
    e.parity = nib[0] ^ nib[1] ^ nib[2] ^ nib[3];
    e.err    = e.parity ^ par;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input int idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_ready != '0) break;
    end
    chk("grant", 32'(req_ready), 32'(oh));
  endtask

  task automatic compare_res();
    exp_t e;
    chk("res_valid_up", 32'(res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty: observed result with id %0d, expected none", res_id);
    end else begin
      e = exp_q.pop_front();
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_parity", 32'(res_parity), 32'(e.parity));
      chk("res_err", 32'(res_err), 32'(e.err));
      last_err = e.err;
    end
  endtask

  task automatic model_hs(input logic clr);
    if (clr) begin
      model_cnt = 0;
      model_led = 1'b0;
    end
    if (last_err) begin
      if (model_cnt < ERR_MAX) model_cnt++;
      model_led = 1'b1;
    end
  endtask

  // One requester alone: grant, fixed latency, optional backpressure, handshake.
  task automatic do_single(input int idx, input logic [3:0] nib, input logic par,
                           input int hold, input logic clr);
    req_data[4*idx +: 4] = nib;
    req_par[idx]         = par;
    req_valid            = '0;
    req_valid[idx]       = 1'b1;
    push_exp(idx, nib, par);
    wait_grant(idx);
    model_rr = (idx + 1) % NUM_REQ;
    tick();
    req_valid = '0;
    chk("ready_one_cycle", 32'(req_ready), 32'd0);
    chk("res_valid_early", 32'(res_valid), 32'd0);
    tick();
    compare_res();
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("res_valid_held", 32'(res_valid), 32'd1);
      chk("err_cnt_hold", 32'(err_cnt), 32'(model_cnt));
    end
    res_ready = 1'b1;
    clr_err   = clr;
    tick();
    res_ready = 1'b0;
    clr_err   = 1'b0;
    model_hs(clr);
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
    chk("led", 32'(led), 32'(model_led));
    chk("res_err_kept", 32'(res_err), 32'(last_err));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'hA5C3;
    req_par   = 4'hF;
    res_ready = 1'b0;
    clr_err   = 1'b0;

    // Reset with every requester pending
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_parity", 32'(res_parity), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();
    chk("idle_no_grant", 32'(req_ready), 32'd0);

    // Single request: nibble B with parity 1
    do_single(0, 4'hB, 1'b1, 2, 1'b0);

    // Round robin with all requesters pending and consumer always ready
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    model_rr = 0;
    req_data  = {4'hF, 4'hE, 4'h1, 4'h3};
    req_par   = 4'b0110;
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = model_rr;
      push_exp(g, req_data[4*g +: 4], req_par[g]);
      wait_grant(g);
      model_rr = (g + 1) % NUM_REQ;
      tick();
      chk("rr_ready_one_cycle", 32'(req_ready), 32'd0);
      tick();
      compare_res();
    end
    req_valid = '0;
    tick();
    res_ready = 1'b0;
    chk("rr_res_valid_drop", 32'(res_valid), 32'd0);
    chk("rr_err_cnt", 32'(err_cnt), 32'd0);

    // Parity error held under backpressure
    do_single(1, 4'h7, 1'b0, 5, 1'b0);

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      do_single(k % NUM_REQ, 4'h1, 1'b0, 0, 1'b0);
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'd3);

    // Plain clear, then clear coinciding with an errored handshake
    clr_err = 1'b1;
    tick();
    clr_err   = 1'b0;
    model_cnt = 0;
    model_led = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_led", 32'(led), 32'd0);
    do_single(0, 4'h8, 1'b0, 0, 1'b1);
    chk("clr_inc_cnt", 32'(err_cnt), 32'd1);

    // Withdrawal in GRANT: no result, pointer unchanged
    req_valid = 4'b0100;
    wait_grant(2);
    req_valid = '0;
    tick();
    chk("wd_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_no_result", 32'(res_valid), 32'd0);
    end

    // All pending again: grant must follow the unchanged pointer; reset in RESP
    req_data  = 16'h7777;
    req_par   = 4'h0;
    req_valid = 4'hF;
    push_exp(model_rr, 4'h7, 1'b0);
    wait_grant(model_rr);
    tick();
    req_valid = '0;
    chk("wd2_res_valid_early", 32'(res_valid), 32'd0);
    tick();
    compare_res();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    model_cnt = 0;
    model_led = 1'b0;
    model_rr  = 0;
    chk("rstresp_res_valid", 32'(res_valid), 32'd0);
    chk("rstresp_err_cnt", 32'(err_cnt), 32'(model_cnt));
    chk("rstresp_led", 32'(led), 32'(model_led));
    chk("rstresp_res_id", 32'(res_id), 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", 32'(res_valid), 32'd0);
    end
    res_ready = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
